// File: rtl/data_sram_responder.sv
// Data-SRAM port responder: byte-enabled word RAM plus LED/switch/timer MMIO, 1-cycle reads.
// Optional feature: define DATA_SRAM_TIMER_EN to build the 32-bit free-running TIMER register.
module data_sram_responder #(
    parameter int          DEPTH_LOG2 = 16,
    parameter logic [15:0] MMIO_HI    = 16'h1faf
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch,
    output logic [15:0] led
);

    localparam int          DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [15:0] LED_OFF = 16'hf000;
    localparam logic [15:0] SW_OFF  = 16'hf020;
`ifdef DATA_SRAM_TIMER_EN
    localparam logic [15:0] TMR_OFF = 16'he000;
`endif

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] idx;
    logic [15:0]           off;
    logic                  is_mmio;
    logic                  is_wr;
    logic                  is_rd;
    logic                  sel_led;
    logic                  sel_sw;
    logic [31:0]           mmio_rdata;
    logic                  unused_addr;

    assign idx         = data_sram_addr[DEPTH_LOG2+1:2];
    assign off         = {data_sram_addr[15:2], 2'b00};
    assign is_mmio     = data_sram_addr[31:16] == MMIO_HI;
    assign is_wr       = data_sram_en && (data_sram_wen != 4'h0);
    assign is_rd       = data_sram_en && (data_sram_wen == 4'h0);
    assign sel_led     = is_mmio && (off == LED_OFF);
    assign sel_sw      = is_mmio && (off == SW_OFF);
    assign unused_addr = ^data_sram_addr[1:0];

`ifdef DATA_SRAM_TIMER_EN
    logic [31:0] timer;
    logic        sel_tmr;

    assign sel_tmr = is_mmio && (off == TMR_OFF);

    // A write cycle loads instead of incrementing; disabled bytes keep the current value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer <= 32'h0;
        end else if (is_wr && sel_tmr) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wen[i]) begin
                    timer[8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end else begin
            timer <= timer + 32'h1;
        end
    end
`endif

    always_comb begin
        mmio_rdata = 32'h0;
        unique case (1'b1)
            sel_led: mmio_rdata = {16'h0, led};
            sel_sw:  mmio_rdata = {24'h0, switch};
`ifdef DATA_SRAM_TIMER_EN
            sel_tmr: mmio_rdata = timer;
`endif
            default: mmio_rdata = 32'h0;
        endcase
    end

    // RAM contents survive reset, so this array has no reset branch.
    always_ff @(posedge clk) begin
        if (is_wr && !is_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wen[i]) begin
                    mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led <= 16'h0;
        end else if (is_wr && sel_led) begin
            if (data_sram_wen[0]) led[7:0]  <= data_sram_wdata[7:0];
            if (data_sram_wen[1]) led[15:8] <= data_sram_wdata[15:8];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_sram_rdata <= 32'h0;
        end else if (is_rd) begin
            data_sram_rdata <= is_mmio ? mmio_rdata : mem[idx];
        end
    end

endmodule
